// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), bout = unsigned borrow-out.
// Latency: start accepted at E0, done pulses after edge E(WIDTH); one result per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy or done, with no queuing.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, a, b, bin: request and operands, captured only on the accepting edge in IDLE
//   busy            : high while bits are being shifted (SHIFT state)
//   done            : one-cycle pulse, diff/bout valid
//   diff, bout      : registered result, held until the next operation completes
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter must hold 0..WIDTH inclusive.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  // One bit of full subtraction on the current LSBs.
  logic             d;
  logic             br_nx;
  logic [WIDTH-1:0] res_nx;
  logic             last_bit;

  assign d        = sa[0] ^ sb[0] ^ br;
  assign br_nx    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // Result fills from the MSB downward so that after WIDTH shifts bit 0 is the first computed bit.
  assign res_nx   = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nx;
          br  <= br_nx;
          cnt <= cnt + CW'(1);
          // diff is only written here so internal shifting never shows on the output.
          if (last_bit) begin
            diff  <= res_nx;
            bout  <= br_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int ncmp = 0;
  int nerr = 0;

  exp_t q8[$];
  exp_t q1[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitors: sampled on the falling edge, away from the active edge.
  int         run8 = 0, run1 = 0;
  logic [7:0] last8 = '0;
  logic       last1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run8  = 0;
      last8 = '0;
    end else begin
      if (busy8) run8++;
      else if (run8 != 0) begin
        chk("busy8_len", run8, 8);
        run8 = 0;
      end
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("diff8", int'(diff8), int'(e.d));
          chk("bout8", int'(bout8), int'(e.bo));
          chk("done8_cycle", cyc, e.cyc);
        end
        last8 = diff8;
      end else begin
        chk("diff8_hold", int'(diff8), int'(last8));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run1  = 0;
      last1 = 1'b0;
    end else begin
      if (busy1) run1++;
      else if (run1 != 0) begin
        chk("busy1_len", run1, 1);
        run1 = 0;
      end
      if (done1) begin
        if (q1.size() == 0) chk("done1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("diff1", int'(diff1), int'(e.d));
          chk("bout1", int'(bout1), int'(e.bo));
          chk("done1_cycle", cyc, e.cyc);
        end
        last1 = diff1[0];
      end else begin
        chk("diff1_hold", int'(diff1), int'(last1));
      end
    end
  end

  // Issue one 8-bit operation; the accepting edge is the next posedge.
  task automatic op8(input logic [7:0] ea, input logic [7:0] eb, input logic ebin,
                     input logic [7:0] ed, input logic ebo);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; a8 = ea; b8 = eb; bin8 = ebin;
    e.d = ed; e.bo = ebo; e.cyc = cyc + 8 + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Full-subtractor truth table for a,b,bin = 0..7 ascending.
  logic [7:0] tt_d  = 8'b1001_0110;
  logic [7:0] tt_bo = 8'b1000_1110;

  initial begin
    exp_t e;
    int   c0;
    logic [2:0] v;

    // Reset state.
    #1 rst = 1'b1;
    #2;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_bout8", bout8, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_diff1", diff1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
    op8(8'd5,   8'd5,  1'b1, 8'd255, 1'b1);
    op8(8'd255, 8'd0,  1'b0, 8'd255, 1'b0);

    // start held high, operands changed during SHIFT: only the first operands
    // are used, the second operation is accepted 10 edges later.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0;
    c0 = cyc + 1;
    e.d = 8'd7;  e.bo = 1'b0; e.cyc = c0 + 8;  q8.push_back(e);
    e.d = 8'd29; e.bo = 1'b0; e.cyc = c0 + 18; q8.push_back(e);
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; bin8 = 1'b1;
    while (cyc < c0 + 10) @(negedge clk);
    start8 = 1'b0; a8 = 8'd1; b8 = 8'd2; bin8 = 1'b0;
    repeat (10) @(negedge clk);

    op8(8'd0, 8'd1, 1'b0, 8'd255, 1'b1);

    // Abort at E4: outputs must clear without a clock, no done pulse.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd77; b8 = 8'd11; bin8 = 1'b0;
    c0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc < c0 + 4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_diff8", diff8, 0);
    chk("abort_bout8", bout8, 0);

    // start during reset is ignored; held across release it is accepted on the first edge.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd201; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_ignored", busy8, 0);
    rst = 1'b0;
    e.d = 8'd255; e.bo = 1'b1; e.cyc = cyc + 1 + 8; q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);

    // WIDTH=1: all combinations ascending.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
      e.d = {7'b0, tt_d[i]}; e.bo = tt_bo[i]; e.cyc = cyc + 1 + 1;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Bounded drain of any outstanding expectations.
    for (int k = 0; k < 50 && (q8.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    while (q8.size() != 0) begin
      e = q8.pop_front();
      chk("missing_done8", 0, 1);
    end
    while (q1.size() != 0) begin
      e = q1.pop_front();
      chk("missing_done1", 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
